// File: rtl/xup_seq_pkg.sv
// Shared types and sizes for the 5-input gate exhaustive-test sequencer.
package xup_seq_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    SETTLE = 2'd1,
    SAMPLE = 2'd2,
    DONE   = 2'd3
  } state_e;

  localparam int NUM_VECTORS  = 32;
  localparam int VEC_W        = 5;
  localparam int SETTLE_CNT_W = 4;

endpackage

// File: rtl/xup_gate5_sequencer.sv
// Walks all 32 stimuli through a 5-input gate, holding each SETTLE_CYCLES+1 cycles,
// captures the truth table and reports pass plus the lowest failing vector; no flow control.
module xup_gate5_sequencer
  import xup_seq_pkg::*;
#(
  parameter int                     SETTLE_CYCLES = 2,  // legal 1..15
  parameter logic [NUM_VECTORS-1:0] EXPECTED      = 32'h7FFF_FFFF
) (
  input  logic                   clk,
  input  logic                   reset_n,
  input  logic                   start,
  input  logic                   abort,
  input  logic                   y_in,
  output logic [VEC_W-1:0]       vec,
  output logic                   busy,
  output logic                   done,
  output logic                   pass,
  output logic [NUM_VECTORS-1:0] truth,
  output logic                   fail_valid,
  output logic [VEC_W-1:0]       fail_index
);

  localparam logic [SETTLE_CNT_W-1:0] CNT_LAST = SETTLE_CNT_W'(SETTLE_CYCLES - 1);
  localparam logic [VEC_W-1:0]        VEC_LAST = VEC_W'(NUM_VECTORS - 1);

  state_e                   state_q, state_d;
  logic [VEC_W-1:0]         vec_q, vec_d;
  logic [SETTLE_CNT_W-1:0]  cnt_q, cnt_d;
  logic [NUM_VECTORS-1:0]   truth_q, truth_d;
  logic                     pass_q, pass_d;
  logic                     fail_valid_q, fail_valid_d;
  logic [VEC_W-1:0]         fail_index_q, fail_index_d;

  always_comb begin
    state_d      = state_q;
    vec_d        = vec_q;
    cnt_d        = cnt_q;
    truth_d      = truth_q;
    pass_d       = pass_q;
    fail_valid_d = fail_valid_q;
    fail_index_d = fail_index_q;

    case (state_q)
      IDLE: begin
        if (start) begin
          vec_d        = '0;
          truth_d      = '0;
          pass_d       = 1'b0;
          fail_valid_d = 1'b0;
          fail_index_d = '0;
          cnt_d        = '0;
          state_d      = SETTLE;
        end
      end

      SETTLE: begin
        if (abort) begin
          state_d = IDLE;
          vec_d   = '0;
          cnt_d   = '0;
          pass_d  = 1'b0;
        end else begin
          cnt_d = cnt_q + 1'b1;
          if (cnt_q == CNT_LAST) state_d = SAMPLE;
        end
      end

      SAMPLE: begin
        // Abort wins: the vector being sampled is not recorded.
        if (abort) begin
          state_d = IDLE;
          vec_d   = '0;
          cnt_d   = '0;
          pass_d  = 1'b0;
        end else begin
          truth_d[vec_q] = y_in;
          if ((y_in != EXPECTED[vec_q]) && !fail_valid_q) begin
            fail_valid_d = 1'b1;
            fail_index_d = vec_q;
          end
          if (vec_q == VEC_LAST) begin
            pass_d  = ({y_in, truth_q[NUM_VECTORS-2:0]} == EXPECTED);
            state_d = DONE;
          end else begin
            vec_d   = vec_q + 1'b1;
            cnt_d   = '0;
            state_d = SETTLE;
          end
        end
      end

      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q      <= IDLE;
      vec_q        <= '0;
      cnt_q        <= '0;
      truth_q      <= '0;
      pass_q       <= 1'b0;
      fail_valid_q <= 1'b0;
      fail_index_q <= '0;
    end else begin
      state_q      <= state_d;
      vec_q        <= vec_d;
      cnt_q        <= cnt_d;
      truth_q      <= truth_d;
      pass_q       <= pass_d;
      fail_valid_q <= fail_valid_d;
      fail_index_q <= fail_index_d;
    end
  end

  assign vec        = vec_q;
  assign busy       = (state_q == SETTLE) || (state_q == SAMPLE);
  assign done       = (state_q == DONE);
  assign pass       = pass_q;
  assign truth      = truth_q;
  assign fail_valid = fail_valid_q;
  assign fail_index = fail_index_q;

endmodule

// File: tb/tb_xup_gate5_sequencer.sv
// Bench: two sequencers (S=2 with a switchable NAND/stuck-at gate, S=1 with a good NAND),
// expected run results queued at start and checked by monitors on each done pulse.
module tb_xup_gate5_sequencer;

  typedef struct {
    logic [31:0] truth;
    logic        pass;
    logic        fv;
    logic [4:0]  fi;
    int          len;
  } exp_t;

  exp_t sb2[$];
  exp_t sb1[$];
  exp_t e2, e1;

  logic        clk = 1'b0;
  logic        rst2_n, rst1_n;
  logic        start2, abort2, start1, abort1;
  logic [1:0]  mode2;
  logic        y2, y1;
  logic [4:0]  vec2, vec1, fi2, fi1;
  logic        busy2, busy1, done2, done1, pass2, pass1, fv2, fv1;
  logic [31:0] truth2, truth1;

  int checks = 0;
  int errs   = 0;
  int cyc    = 0;
  int t0_2   = 0;
  int t0_1   = 0;
  int vec_err2 = 0;
  int vec_err1 = 0;
  logic busy2_p = 1'b0;
  logic busy1_p = 1'b0;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  // 5-input NAND under test; mode 1/2 plant stuck-at-1/stuck-at-0 output faults.
  assign y2 = (mode2 == 2'd0) ? ~&vec2 : (mode2 == 2'd1) ? 1'b1 : 1'b0;
  assign y1 = ~&vec1;

  xup_gate5_sequencer #(.SETTLE_CYCLES(2), .EXPECTED(32'h7FFF_FFFF)) u_dut2 (
    .clk(clk), .reset_n(rst2_n), .start(start2), .abort(abort2), .y_in(y2),
    .vec(vec2), .busy(busy2), .done(done2), .pass(pass2), .truth(truth2),
    .fail_valid(fv2), .fail_index(fi2)
  );

  xup_gate5_sequencer #(.SETTLE_CYCLES(1), .EXPECTED(32'h7FFF_FFFF)) u_dut1 (
    .clk(clk), .reset_n(rst1_n), .start(start1), .abort(abort1), .y_in(y1),
    .vec(vec1), .busy(busy1), .done(done1), .pass(pass1), .truth(truth1),
    .fail_valid(fv1), .fail_index(fi1)
  );

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errs++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", nm, act, exp);
    end
  endtask

  always @(negedge clk) begin
    if (busy2 && !busy2_p) vec_err2 = 0;
    if (busy2 && (vec2 != 5'((cyc - t0_2) / 3))) vec_err2++;
    if (done2) begin
      if (sb2.size() == 0) begin
        checks++;
        errs++;
        $display("FAIL dut2_unexpected_done: got done=1 expected done=0");
      end else begin
        e2 = sb2.pop_front();
        chk("dut2_truth", truth2, e2.truth);
        chk("dut2_pass", 32'(pass2), 32'(e2.pass));
        chk("dut2_fail_valid", 32'(fv2), 32'(e2.fv));
        chk("dut2_fail_index", 32'(fi2), 32'(e2.fi));
        chk("dut2_run_len", 32'(cyc - t0_2), 32'(e2.len));
        chk("dut2_vec_step_errs", 32'(vec_err2), 32'd0);
      end
    end
    busy2_p = busy2;
  end

  always @(negedge clk) begin
    if (busy1 && !busy1_p) vec_err1 = 0;
    if (busy1 && (vec1 != 5'((cyc - t0_1) / 2))) vec_err1++;
    if (done1) begin
      if (sb1.size() == 0) begin
        checks++;
        errs++;
        $display("FAIL dut1_unexpected_done: got done=1 expected done=0");
      end else begin
        e1 = sb1.pop_front();
        chk("dut1_truth", truth1, e1.truth);
        chk("dut1_pass", 32'(pass1), 32'(e1.pass));
        chk("dut1_fail_valid", 32'(fv1), 32'(e1.fv));
        chk("dut1_fail_index", 32'(fi1), 32'(e1.fi));
        chk("dut1_run_len", 32'(cyc - t0_1), 32'(e1.len));
        chk("dut1_vec_step_errs", 32'(vec_err1), 32'd0);
      end
    end
    busy1_p = busy1;
  end

  task automatic do_start2();
    @(negedge clk);
    start2 = 1'b1;
    @(posedge clk);
    #1;
    t0_2   = cyc;
    start2 = 1'b0;
  endtask

  task automatic do_start1();
    @(negedge clk);
    start1 = 1'b1;
    @(posedge clk);
    #1;
    t0_1   = cyc;
    start1 = 1'b0;
  endtask

  task automatic wait_done2(input int budget);
    int n = 0;
    while (!done2 && n < budget) begin
      @(negedge clk);
      n++;
    end
    if (!done2) chk("dut2_done_timeout", 32'(done2), 32'd1);
  endtask

  task automatic wait_done1(input int budget);
    int n = 0;
    while (!done1 && n < budget) begin
      @(negedge clk);
      n++;
    end
    if (!done1) chk("dut1_done_timeout", 32'(done1), 32'd1);
  endtask

  task automatic push2(input logic [31:0] t, input logic p, input logic fv,
                       input logic [4:0] fi, input int len);
    exp_t e;
    e.truth = t; e.pass = p; e.fv = fv; e.fi = fi; e.len = len;
    sb2.push_back(e);
  endtask

  initial begin
    int n;
    rst2_n = 1'b1; rst1_n = 1'b1;
    start2 = 1'b0; abort2 = 1'b0; start1 = 1'b0; abort1 = 1'b0;
    mode2  = 2'd0;

    // Asynchronous reset asserted between clock edges.
    #2;
    rst2_n = 1'b0; rst1_n = 1'b0;
    #1;
    chk("rst_vec", 32'(vec2), 32'd0);
    chk("rst_busy", 32'(busy2), 32'd0);
    chk("rst_done", 32'(done2), 32'd0);
    chk("rst_pass", 32'(pass2), 32'd0);
    chk("rst_truth", truth2, 32'd0);
    chk("rst_fail_valid", 32'(fv2), 32'd0);
    chk("rst_fail_index", 32'(fi2), 32'd0);
    @(negedge clk);
    rst2_n = 1'b1; rst1_n = 1'b1;
    repeat (10) @(negedge clk);
    chk("idle_busy", 32'(busy2), 32'd0);
    chk("idle_vec", 32'(vec2), 32'd0);

    // Good NAND, with start pulses during the run and in the DONE cycle.
    push2(32'h7FFF_FFFF, 1'b1, 1'b0, 5'd0, 96);
    do_start2();
    repeat (40) @(negedge clk);
    start2 = 1'b1;
    @(negedge clk);
    start2 = 1'b0;
    wait_done2(200);
    start2 = 1'b1;
    @(negedge clk);
    start2 = 1'b0;
    chk("after_done_busy", 32'(busy2), 32'd0);
    chk("after_done_vec_hold", 32'(vec2), 32'd31);
    chk("after_done_pass_hold", 32'(pass2), 32'd1);
    repeat (3) @(negedge clk);
    chk("done_start_ignored", 32'(busy2), 32'd0);

    mode2 = 2'd1;
    push2(32'hFFFF_FFFF, 1'b0, 1'b1, 5'd31, 96);
    do_start2();
    wait_done2(200);

    mode2 = 2'd2;
    push2(32'h0000_0000, 1'b0, 1'b1, 5'd0, 96);
    do_start2();
    wait_done2(200);

    // Abort at vec=10.
    mode2 = 2'd0;
    do_start2();
    n = 0;
    while (vec2 != 5'd10 && n < 100) begin
      @(negedge clk);
      n++;
    end
    chk("abort_reach_vec10", 32'(vec2), 32'd10);
    abort2 = 1'b1;
    @(posedge clk);
    #1;
    abort2 = 1'b0;
    chk("abort_busy", 32'(busy2), 32'd0);
    chk("abort_vec", 32'(vec2), 32'd0);
    chk("abort_done", 32'(done2), 32'd0);
    chk("abort_truth", truth2, 32'h0000_03FF);
    chk("abort_pass", 32'(pass2), 32'd0);
    chk("abort_fail_valid", 32'(fv2), 32'd0);
    repeat (10) @(negedge clk);
    chk("abort_stays_idle", 32'(busy2), 32'd0);

    // S=1: reset mid-run at vec=20, then a full clean run.
    do_start1();
    n = 0;
    while (vec1 != 5'd20 && n < 100) begin
      @(negedge clk);
      n++;
    end
    chk("rst_run_reach_vec20", 32'(vec1), 32'd20);
    @(posedge clk);
    #2;
    rst1_n = 1'b0;
    #1;
    chk("midrun_rst_busy", 32'(busy1), 32'd0);
    chk("midrun_rst_vec", 32'(vec1), 32'd0);
    chk("midrun_rst_truth", truth1, 32'd0);
    chk("midrun_rst_fail_valid", 32'(fv1), 32'd0);
    chk("midrun_rst_fail_index", 32'(fi1), 32'd0);
    @(negedge clk);
    rst1_n = 1'b1;
    repeat (5) @(negedge clk);
    chk("midrun_rst_no_resume", 32'(busy1), 32'd0);
    begin
      exp_t e;
      e.truth = 32'h7FFF_FFFF; e.pass = 1'b1; e.fv = 1'b0; e.fi = 5'd0; e.len = 64;
      sb1.push_back(e);
    end
    do_start1();
    wait_done1(200);
    repeat (3) @(negedge clk);

    chk("sb2_drained", 32'(sb2.size()), 32'd0);
    chk("sb1_drained", 32'(sb1.size()), 32'd0);
    $display("Result: errors=%0d of %0d checks", errs, checks);
    $finish;
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog expired");
  end

endmodule
